// File: rtl/rv_pkg.sv
// Shared RV32I constants, decoded-instruction layout and ALU helper.
package rv_pkg;

  localparam int unsigned XLEN     = 32;
  localparam int unsigned REG_AW   = 5;
  localparam int unsigned NUM_REGS = 32;

  localparam logic [6:0] OP     = 7'b0110011;
  localparam logic [6:0] OP_IMM = 7'b0010011;
  localparam logic [6:0] LUI    = 7'b0110111;
  localparam logic [6:0] AUIPC  = 7'b0010111;
  localparam logic [6:0] JAL    = 7'b1101111;
  localparam logic [6:0] JALR   = 7'b1100111;
  localparam logic [6:0] BRANCH = 7'b1100011;

  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_SLT  = 3'b010;
  localparam logic [2:0] F3_SLTU = 3'b011;
  localparam logic [2:0] F3_XOR  = 3'b100;
  localparam logic [2:0] F3_SR   = 3'b101;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_AND  = 3'b111;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  // R-type field view of a raw instruction word; other formats are rebuilt from it.
  typedef struct packed {
    logic [6:0] funct7;
    logic [4:0] rs2;
    logic [4:0] rs1;
    logic [2:0] funct3;
    logic [4:0] rd;
    logic [6:0] opcode;
  } inst_t;

  // Shared integer ALU; alt selects SUB / SRA.
  function automatic logic [XLEN-1:0] alu(input logic [2:0] f3, input logic alt,
                                          input logic [XLEN-1:0] a, input logic [XLEN-1:0] b);
    logic [XLEN-1:0] r;
    case (f3)
      F3_ADD:  r = alt ? (a - b) : (a + b);
      F3_SLL:  r = a << b[4:0];
      F3_SLT:  r = XLEN'($signed(a) < $signed(b));
      F3_SLTU: r = XLEN'(a < b);
      F3_XOR:  r = a ^ b;
      F3_SR:   r = alt ? XLEN'($signed(a) >>> b[4:0]) : (a >> b[4:0]);
      F3_OR:   r = a | b;
      default: r = a & b;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/core.sv
// Single-cycle RV32I integer core: pc, decode, ALU, branch compare, register file.
module core import rv_pkg::*; #(
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [XLEN-1:0] inst,
  output logic [XLEN-1:0] pc
);

  inst_t           d;
  logic [XLEN-1:0] imm_i, imm_u, imm_b, imm_j;
  logic [XLEN-1:0] rs1_val_c, rs2_val_c;
  logic [XLEN-1:0] pc_seq, pc_next_c, wdata_c;
  logic            we_c, taken_c;

  assign d      = inst_t'(inst);
  assign imm_i  = {{20{d.funct7[6]}}, d.funct7, d.rs2};
  assign imm_u  = {d.funct7, d.rs2, d.rs1, d.funct3, 12'b0};
  assign imm_b  = {{20{d.funct7[6]}}, d.rd[0], d.funct7[5:0], d.rd[4:1], 1'b0};
  assign imm_j  = {{12{d.funct7[6]}}, d.rs1, d.funct3, d.rs2[0], d.funct7[5:0], d.rs2[4:1], 1'b0};
  assign pc_seq = pc + XLEN'(4);

  regs regs_inst (
    .clk      (clk),
    .rst_n    (rst_n),
    .raddr1   (d.rs1),
    .raddr2   (d.rs2),
    .we       (we_c),
    .waddr    (d.rd),
    .wdata    (wdata_c),
    .rdata1_c (rs1_val_c),
    .rdata2_c (rs2_val_c)
  );

  // Branch condition from funct3; undefined funct3 never branches.
  always_comb begin
    taken_c = 1'b0;
    case (d.funct3)
      F3_BEQ:  taken_c = (rs1_val_c == rs2_val_c);
      F3_BNE:  taken_c = (rs1_val_c != rs2_val_c);
      F3_BLT:  taken_c = ($signed(rs1_val_c) <  $signed(rs2_val_c));
      F3_BGE:  taken_c = ($signed(rs1_val_c) >= $signed(rs2_val_c));
      F3_BLTU: taken_c = (rs1_val_c <  rs2_val_c);
      F3_BGEU: taken_c = (rs1_val_c >= rs2_val_c);
      default: taken_c = 1'b0;
    endcase
  end

  // Writeback value and next pc; unsupported opcodes fall through as NOP.
  always_comb begin
    we_c      = 1'b0;
    wdata_c   = '0;
    pc_next_c = pc_seq;
    case (d.opcode)
      LUI: begin
        we_c    = 1'b1;
        wdata_c = imm_u;
      end
      AUIPC: begin
        we_c    = 1'b1;
        wdata_c = pc + imm_u;
      end
      JAL: begin
        we_c      = 1'b1;
        wdata_c   = pc_seq;
        pc_next_c = pc + imm_j;
      end
      JALR: begin
        we_c      = 1'b1;
        wdata_c   = pc_seq;
        pc_next_c = (rs1_val_c + imm_i) & ~XLEN'(1);
      end
      BRANCH: begin
        if (taken_c) pc_next_c = pc + imm_b;
      end
      OP_IMM: begin
        we_c    = 1'b1;
        wdata_c = alu(d.funct3, (d.funct3 == F3_SR) && d.funct7[5], rs1_val_c, imm_i);
      end
      OP: begin
        we_c    = 1'b1;
        wdata_c = alu(d.funct3, d.funct7[5], rs1_val_c, rs2_val_c);
      end
      default: ;
    endcase
  end

  // Program counter; reset holds it at RESET_PC.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pc <= RESET_PC;
    else        pc <= pc_next_c;
  end

endmodule

// File: rtl/regs.sv
// 32 x XLEN register file: two combinational reads, one synchronous write, x0 fixed at 0.
module regs import rv_pkg::*; (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [REG_AW-1:0] raddr1,
  input  logic [REG_AW-1:0] raddr2,
  input  logic              we,
  input  logic [REG_AW-1:0] waddr,
  input  logic [XLEN-1:0]   wdata,
  output logic [XLEN-1:0]   rdata1_c,
  output logic [XLEN-1:0]   rdata2_c
);

  logic [XLEN-1:0] regs [0:NUM_REGS-1];

  // Clear on reset; writes to x0 are dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else if (we && (waddr != '0)) begin
      regs[waddr] <= wdata;
    end
  end

  assign rdata1_c = (raddr1 == '0) ? '0 : regs[raddr1];
  assign rdata2_c = (raddr2 == '0) ? '0 : regs[raddr2];

endmodule

// File: rtl/rom.sv
// Instruction ROM with combinational word fetch; address wraps past the end.
module rom import rv_pkg::*; #(
  parameter int unsigned ROM_DEPTH = 4096
) (
  input  logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] inst_c
);

  localparam int unsigned AW = $clog2(ROM_DEPTH);

  logic [XLEN-1:0] rom_mem [0:ROM_DEPTH-1];
  logic            unused_pc_bits;

  // Byte offset and bits above the ROM index do not take part in the fetch.
  assign unused_pc_bits = ^{pc[XLEN-1:AW+2], pc[1:0]};
  assign inst_c         = rom_mem[pc[AW+1:2]];

endmodule

// File: rtl/soc_top.sv
// Minimal SoC: RV32I core fetching from an instruction ROM.
module soc_top import rv_pkg::*; #(
  parameter int unsigned     ROM_DEPTH = 4096,
  parameter logic [XLEN-1:0] RESET_PC  = 32'h0
) (
  input logic clk,
  input logic rst_n
);

  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] inst_c;

  rom #(.ROM_DEPTH(ROM_DEPTH)) rom_inst (
    .pc     (pc),
    .inst_c (inst_c)
  );

  core #(.RESET_PC(RESET_PC)) core_inst (
    .clk   (clk),
    .rst_n (rst_n),
    .inst  (inst_c),
    .pc    (pc)
  );

endmodule

// File: tb/tb_soc_top.sv
// Bench for soc_top: instruction-set model compared every cycle plus directed programs.
module tb_soc_top;

  logic clk;
  logic rst_n;

  soc_top soc_inst (.clk(clk), .rst_n(rst_n));

  initial begin
    clk = 1'b1;
    forever #10 clk = ~clk;
  end

  int tests = 0;
  int fails = 0;
  logic chk_en = 1'b0;
  logic trace  = 1'b0;

  logic [31:0] mrom   [0:4095];
  logic [31:0] m_regs [0:31];
  logic [31:0] m_pc;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] dut_reg(input int i);
    return soc_inst.core_inst.regs_inst.regs[i[4:0]];
  endfunction

  // ---------- instruction encoders ----------
  function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                        input logic [2:0] f3, input logic [4:0] rd, input logic [6:0] op);
    return {imm, rs1, f3, rd, op};
  endfunction
  function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2, input logic [4:0] rs1,
                                        input logic [2:0] f3, input logic [4:0] rd, input logic [6:0] op);
    return {f7, rs2, rs1, f3, rd, op};
  endfunction
  function automatic logic [31:0] enc_u(input logic [19:0] imm, input logic [4:0] rd, input logic [6:0] op);
    return {imm, rd, op};
  endfunction
  function automatic logic [31:0] enc_b(input logic [12:0] imm, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3);
    return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'b1100011};
  endfunction
  function automatic logic [31:0] enc_j(input logic [20:0] imm, input logic [4:0] rd);
    return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'b1101111};
  endfunction

  // ---------- architectural reference model ----------
  task automatic model_reset();
    for (int i = 0; i < 32; i++) m_regs[i] = 32'h0;
    m_pc = 32'h0;
  endtask

  function automatic logic [31:0] ref_alu(input logic [2:0] f3, input logic alt,
                                          input logic [31:0] a, input logic [31:0] b);
    int unsigned sh;
    sh = b % 32;
    case (f3)
      3'd0: return alt ? a - b : a + b;
      3'd1: return a << sh;
      3'd2: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      3'd3: return (a < b) ? 32'd1 : 32'd0;
      3'd4: return a ^ b;
      3'd5: return alt ? 32'($signed(a) >>> sh) : a >> sh;
      3'd6: return a | b;
      default: return a & b;
    endcase
  endfunction

  task automatic model_step();
    logic [31:0] in, a, b, res, nxt, immi, immu, immb, immj;
    logic [4:0]  rd;
    logic [2:0]  f3;
    logic        wr, take;
    in   = mrom[m_pc[13:2]];
    rd   = in[11:7];
    f3   = in[14:12];
    a    = m_regs[in[19:15]];
    b    = m_regs[in[24:20]];
    immi = 32'($signed(in) >>> 20);
    immu = in & 32'hFFFFF000;
    immb = (32'($signed(in) >>> 19) & 32'hFFFFF000) | (32'(in[7]) << 11)
         | (32'(in[30:25]) << 5) | (32'(in[11:8]) << 1);
    immj = (32'($signed(in) >>> 11) & 32'hFFF00000) | (in & 32'h000FF000)
         | (32'(in[20]) << 11) | (32'(in[30:21]) << 1);
    nxt  = m_pc + 32'd4;
    wr   = 1'b0;
    res  = 32'h0;
    take = 1'b0;
    case (in[6:0])
      7'b0110111: begin wr = 1'b1; res = immu; end
      7'b0010111: begin wr = 1'b1; res = m_pc + immu; end
      7'b1101111: begin wr = 1'b1; res = m_pc + 32'd4; nxt = m_pc + immj; end
      7'b1100111: begin wr = 1'b1; res = m_pc + 32'd4; nxt = (a + immi) & 32'hFFFFFFFE; end
      7'b1100011: begin
        case (f3)
          3'd0: take = (a == b);
          3'd1: take = (a != b);
          3'd4: take = ($signed(a) <  $signed(b));
          3'd5: take = ($signed(a) >= $signed(b));
          3'd6: take = (a <  b);
          3'd7: take = (a >= b);
          default: take = 1'b0;
        endcase
        if (take) nxt = m_pc + immb;
      end
      7'b0010011: begin wr = 1'b1; res = ref_alu(f3, (f3 == 3'd5) && in[30], a, immi); end
      7'b0110011: begin wr = 1'b1; res = ref_alu(f3, in[30], a, b); end
      default: ;
    endcase
    if (wr && rd != 5'd0) m_regs[rd] = res;
    m_pc = nxt;
  endtask

  // Model advances on the same events that update the DUT.
  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) model_reset();
    else        model_step();
  end

  // Compare the whole architectural state on every falling edge.
  initial forever begin
    @(negedge clk);
    if (chk_en) begin
      for (int i = 0; i < 32; i++) chk($sformatf("x%0d", i), dut_reg(i), m_regs[i]);
      chk("pc", soc_inst.core_inst.pc, m_pc);
      if (trace)
        $display("[TB] t=%0t x27=%h x28=%h x29=%h", $time, dut_reg(27), dut_reg(28), dut_reg(29));
    end
  end

  // ---------- program loading / running ----------
  task automatic load_prog(input logic [31:0] p[$]);
    for (int i = 0; i < 4096; i++) begin
      mrom[i] = 32'h0;
      soc_inst.rom_inst.rom_mem[i] = 32'h0;
    end
    foreach (p[i]) begin
      mrom[i] = p[i];
      soc_inst.rom_inst.rom_mem[i] = p[i];
    end
    model_reset();
  endtask

  task automatic run_prog(input logic [31:0] p[$], input int ncyc);
    rst_n = 1'b0;
    load_prog(p);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (ncyc) @(negedge clk);
  endtask

  // Literal expectation checked against both the DUT and the model.
  task automatic pin(input string name, input int r, input logic [31:0] exp);
    chk(name, dut_reg(r), exp);
    chk({name, "_model"}, m_regs[r], exp);
  endtask

  function automatic logic [31:0] rand_inst();
    int unsigned k;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  f3;
    logic [11:0] i12;
    logic [6:0]  f7;
    int          off;
    rd  = 5'($urandom_range(0, 7));
    rs1 = 5'($urandom_range(0, 7));
    rs2 = 5'($urandom_range(0, 7));
    f3  = 3'($urandom);
    i12 = 12'($urandom);
    k   = $urandom_range(0, 9);
    case (k)
      0, 1: begin
        if (f3 == 3'd1) i12 = {7'h00, i12[4:0]};
        if (f3 == 3'd5) i12 = {($urandom_range(0, 1) != 0) ? 7'h20 : 7'h00, i12[4:0]};
        return enc_i(i12, rs1, f3, rd, 7'b0010011);
      end
      2, 3: begin
        f7 = ((f3 == 3'd0 || f3 == 3'd5) && $urandom_range(0, 1) != 0) ? 7'h20 : 7'h00;
        return enc_r(f7, rs2, rs1, f3, rd, 7'b0110011);
      end
      4: return enc_u(20'($urandom), rd, 7'b0110111);
      5: return enc_u(20'($urandom), rd, 7'b0010111);
      6: begin
        if (f3 == 3'd2 || f3 == 3'd3) f3 = 3'd1;
        off = (int'($urandom_range(0, 12)) - 4) * 4;
        return enc_b(13'(off), rs2, rs1, f3);
      end
      7: begin
        off = (int'($urandom_range(0, 10)) - 3) * 4;
        return enc_j(21'(off), rd);
      end
      8: return enc_i(i12, rs1, 3'd0, rd, 7'b1100111);
      default: return {25'($urandom), (k[0] ? 7'b0000011 : 7'b0100011)};
    endcase
  endfunction

  initial begin
    logic [31:0] p[$];
    rst_n  = 1'b0;
    chk_en = 1'b1;
    trace  = 1'b1;

    // Reset state and basic add: released at t=30.
    p = {enc_i(12'd5, 5'd0, 3'd0, 5'd27, 7'b0010011),
         enc_i(12'hFFD, 5'd0, 3'd0, 5'd28, 7'b0010011),
         enc_r(7'h00, 5'd28, 5'd27, 3'd0, 5'd29, 7'b0110011)};
    rst_n = 1'b0;
    load_prog(p);
    @(negedge clk);
    chk("reset_x27", dut_reg(27), 32'h0);
    chk("reset_pc", soc_inst.core_inst.pc, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    pin("add_x27", 27, 32'd5);
    pin("add_x28", 28, 32'hFFFFFFFD);
    pin("add_x29", 29, 32'd2);

    // LUI + ADDI build a constant, SUB negates it.
    p = {enc_u(20'h12345, 5'd27, 7'b0110111),
         enc_i(12'h678, 5'd27, 3'd0, 5'd27, 7'b0010011),
         enc_r(7'h20, 5'd27, 5'd0, 3'd0, 5'd28, 7'b0110011)};
    run_prog(p, 3);
    pin("lui_x27", 27, 32'h12345678);
    pin("sub_x28", 28, 32'hEDCBA988);

    // Counting loop closed by BNE.
    p = {enc_i(12'd0, 5'd0, 3'd0, 5'd27, 7'b0010011),
         enc_i(12'd10, 5'd0, 3'd0, 5'd28, 7'b0010011),
         enc_i(12'd1, 5'd27, 3'd0, 5'd27, 7'b0010011),
         enc_b(13'h1FFC, 5'd28, 5'd27, 3'b001),
         enc_i(12'd1, 5'd0, 3'd0, 5'd29, 7'b0010011)};
    run_prog(p, 30);
    pin("loop_x27", 27, 32'd10);
    pin("loop_x29", 29, 32'd1);

    // JAL skips one word and links pc+4.
    p = {enc_j(21'd8, 5'd28),
         enc_i(12'd9, 5'd0, 3'd0, 5'd27, 7'b0010011)};
    run_prog(p, 2);
    pin("jal_x28", 28, 32'd4);
    pin("jal_x27", 27, 32'd0);

    // x0 write discarded; unknown opcode is a NOP.
    p = {enc_i(12'd7, 5'd0, 3'd0, 5'd0, 7'b0010011),
         enc_r(7'h00, 5'd0, 5'd0, 3'd0, 5'd27, 7'b0110011),
         32'h00000003,
         enc_i(12'd1, 5'd0, 3'd0, 5'd29, 7'b0010011)};
    run_prog(p, 3);
    pin("x0_x27", 27, 32'd0);
    pin("nop_x29", 29, 32'd0);
    chk("nop_pc", soc_inst.core_inst.pc, 32'd12);
    @(negedge clk);
    pin("after_nop_x29", 29, 32'd1);

    // Reset mid-loop clears state at once, then the program reruns.
    p = {enc_i(12'd0, 5'd0, 3'd0, 5'd27, 7'b0010011),
         enc_i(12'd10, 5'd0, 3'd0, 5'd28, 7'b0010011),
         enc_i(12'd1, 5'd27, 3'd0, 5'd27, 7'b0010011),
         enc_b(13'h1FFC, 5'd28, 5'd27, 3'b001),
         enc_i(12'd1, 5'd0, 3'd0, 5'd29, 7'b0010011)};
    run_prog(p, 9);
    chk("pre_rst_x28", dut_reg(28), 32'd10);
    #5 rst_n = 1'b0;
    #1;
    chk("rst_x27", dut_reg(27), 32'h0);
    chk("rst_x28", dut_reg(28), 32'h0);
    chk("rst_x29", dut_reg(29), 32'h0);
    chk("rst_pc", soc_inst.core_inst.pc, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (30) @(negedge clk);
    pin("rerun_x27", 27, 32'd10);
    pin("rerun_x28", 28, 32'd10);
    pin("rerun_x29", 29, 32'd1);

    // Random programs checked cycle by cycle against the model.
    trace = 1'b0;
    for (int n = 0; n < 12; n++) begin
      p = {};
      for (int i = 0; i < 32; i++) p.push_back(rand_inst());
      run_prog(p, 80);
    end

    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
